// File: rtl/port_toggle_responder_if.sv
// Toggle-handshake request port bundle.
// The requester drives master; the responder drives slave.
interface port_toggle_responder_if #(
    parameter int AW = 14
);
    logic          port_req;
    logic          port_ack;
    logic [AW-1:0] port_a;
    logic [1:0]    port_ds;
    logic          port_we;
    logic [15:0]   port_d;
    logic [15:0]   port_q;

    modport master (
        output port_req, port_a, port_ds, port_we, port_d,
        input  port_ack, port_q
    );

    modport slave (
        input  port_req, port_a, port_ds, port_we, port_d,
        output port_ack, port_q
    );
endinterface

// File: rtl/port_toggle_responder.sv
// Toggle-handshake word memory with byte strobes, wait states
// and an independent free-running registered read port.
module port_toggle_responder #(
    parameter int AW   = 14,
    parameter int WAIT = 2
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    port_toggle_responder_if.slave  port,
    input  logic [AW-1:0]           cpu_addr,
    output logic [15:0]             cpu_q,
    output logic                    busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] WLAST = 4'(WAIT - 1);

    state_t        state, state_d;
    logic [3:0]    cnt, cnt_d;
    logic          req_q;
    logic          ack;
    logic [15:0]   q;
    logic          cap;
    logic          pending;

    logic [AW-1:0] a_q;
    logic [1:0]    ds_q;
    logic          we_q;
    logic [15:0]   d_q;

    logic [15:0]   mem [2**AW];

    // req is registered once; the edge that samples it starts the latency
    assign pending = req_q != ack;
    assign busy    = state != S_IDLE;

    assign port.port_ack = ack;
    assign port.port_q   = q;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cap     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (pending) begin
                    cap     = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = (WAIT > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt == WLAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            req_q <= 1'b0;
            ack   <= 1'b0;
            q     <= 16'h0000;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            req_q <= port.port_req;
            if (state == S_DONE) begin
                ack <= ~ack;
                if (!we_q) begin
                    q <= mem[a_q];
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (cap) begin
            a_q  <= port.port_a;
            ds_q <= port.port_ds;
            we_q <= port.port_we;
            d_q  <= port.port_d;
        end
    end

    // storage is never cleared; reset only blocks an in-flight write
    always_ff @(posedge clk_sys) begin
        if (!reset && state == S_ACCESS && we_q) begin
            if (ds_q[1]) begin
                mem[a_q][15:8] <= d_q[15:8];
            end
            if (ds_q[0]) begin
                mem[a_q][7:0] <= d_q[7:0];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        cpu_q <= mem[cpu_addr];
    end
endmodule

// File: doc/port_toggle_responder.md
PORT_TOGGLE_RESPONDER -- requirements
Module: port_toggle_responder

Interface
REQ-001 SHALL have parameter AW, default 14, meaning word-address width; the backing store is 2^AW x 16 bits.
REQ-002 SHALL have parameter WAIT, default 2, range 0-15, meaning extra wait cycles inserted before each access.
REQ-003 SHALL have port clk_sys  in  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port port_req  in  1  meaning request toggle; a request is pending when port_req != port_ack.
REQ-006 SHALL have port port_ack  out  1  meaning acknowledge toggle; it equals port_req once the request completes.
REQ-007 SHALL have port port_a  in  AW  meaning word address of the request.
REQ-008 SHALL have port port_ds  in  2  meaning byte strobes; bit1 selects [15:8] and bit0 selects [7:0].
REQ-009 SHALL have port port_we  in  1  meaning 1 = write, 0 = read.
REQ-010 SHALL have port port_d  in  16  meaning write data.
REQ-011 SHALL have port port_q  out  16  meaning read data, valid from the cycle port_ack toggles.
REQ-012 SHALL have port cpu_addr  in  AW  meaning address of the free-running read port.
REQ-013 SHALL have port cpu_q  out  16  meaning data of the free-running read port.
REQ-014 SHALL have port busy  out  1  meaning high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACCESS, DONE.
REQ-016 SHALL, in IDLE with port_req != port_ack, capture port_a, port_ds, port_we and port_d, then go to WAIT when WAIT > 0, otherwise to ACCESS.
REQ-017 SHALL count WAIT cycles in WAIT, then go to ACCESS.
REQ-018 SHALL, in ACCESS on a write, write each byte whose captured ds bit is 1 and leave the other bytes unchanged.
REQ-019 SHALL treat a write with ds = 00 as a no-op that is still acknowledged.
REQ-020 SHALL, in ACCESS on a read, read the full captured word regardless of ds.
REQ-021 SHALL, in DONE, load port_q (read data on a read; unchanged on a write), toggle port_ack, and return to IDLE.
REQ-022 SHALL have a latency of WAIT+3 edges from the edge that samples the request to the edge that toggles port_ack.
REQ-023 SHALL ignore port_req, port_a, port_ds, port_we and port_d while busy = 1.
REQ-024 SHALL, for a requester that toggles port_req twice while busy, leave port_req == port_ack after the ack, so that request is lost (protocol violation; no error flag).
REQ-025 SHALL start the next request no earlier than the edge after DONE, because IDLE always takes at least one cycle.
REQ-026 SHALL register cpu_q from cpu_addr with 1-cycle latency, every cycle, independent of the FSM.
REQ-027 SHALL, when cpu_addr equals the ACCESS write address in the same cycle, return the old data on cpu_q; the new data appears from the next read.
REQ-028 SHALL, for addresses within 2^AW, perform no address wrap or truncation beyond AW bits.
REQ-029 SHALL leave memory contents undefined at power-up and SHALL NOT clear them on reset.

Reset
REQ-030 SHALL, while reset = 1, hold port_ack = 0, port_q = 0000h, busy = 0, FSM = IDLE and the wait counter = 0.
REQ-031 SHALL, on reset during WAIT, abort the request: no memory write and no ack.
REQ-032 SHALL, on reset in the same cycle as ACCESS, suppress the memory write.
REQ-033 SHALL leave cpu_q reset-independent; it keeps tracking memory during reset.
REQ-034 SHALL, when port_req = 1 as reset releases, treat this as a pending request and serve it.

Verification
REQ-035 SHALL cover: WAIT = 2; write A=0010h, D=BEEFh, ds=11, toggle req -> ack toggles 5 edges later; cpu_addr = 0010h -> cpu_q = BEEFh.
REQ-036 SHALL cover: preload 0020h = 1234h; write D=ABCDh, ds=10 -> memory = AB34h; then read 0020h -> port_q = AB34h at the ack toggle.
REQ-037 SHALL cover: write with ds=00 to 0030h holding 5555h -> ack toggles, memory stays 5555h.
REQ-038 SHALL cover: reset asserted one cycle into WAIT of a write 0040h = FFFFh -> port_ack = 0, busy = 0, memory at 0040h unchanged.
REQ-039 SHALL cover: 64 back-to-back requests, each issued on the cycle after ack with random addr/data/ds -> port_q matches a reference model and every ack arrives exactly WAIT+3 edges after its request is sampled.
REQ-040 SHALL cover: cpu_addr held at the write address during ACCESS -> cpu_q shows old data for one cycle, then new data.
